// File: rtl/collision_arbiter.sv
// collision_arbiter: latches object overlaps while the raster scans a frame and,
// on each startOfFrame, issues one-cycle collision pulses for the frame just closed.
//
// Optional feature: define COLLISION_LIVE_EN to add live_hit_o, a registered
// OR of every raw overlap term seen in SCAN or REPORT.
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   start_of_frame_i        one-cycle frame pulse from the VGA controller
//   pixel_x_i, pixel_y_i    current raster position
//   *_dr_i                  per-object drawing requests
//   score_clear_i           synchronous clear of hit_count_o (wins over increment)
//   alien_hit_o             missile hit alien in the closed frame (one-cycle pulse)
//   player_hit_o            bomb hit player, suppressed during the grace period
//   shield_hit_o            missile or bomb hit a shield
//   missile_out_o           missile hit border without hitting an alien
//   hit_x_o, hit_y_o        coordinate of the first alien-hit pixel of the last hit frame
//   hit_count_o             saturating alien-hit count
//   live_hit_o              (COLLISION_LIVE_EN only) overlap seen on the previous cycle
module collision_arbiter #(
   parameter int unsigned COUNT_W      = 8,
   parameter int unsigned GRACE_FRAMES = 60
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               start_of_frame_i,
   input  logic [10:0]        pixel_x_i,
   input  logic [10:0]        pixel_y_i,
   input  logic               alien_dr_i,
   input  logic               player_dr_i,
   input  logic               missile_dr_i,
   input  logic               bomb_dr_i,
   input  logic               shield_dr_i,
   input  logic               border_dr_i,
   input  logic               score_clear_i,
   output logic               alien_hit_o,
   output logic               player_hit_o,
   output logic               shield_hit_o,
   output logic               missile_out_o,
   output logic [10:0]        hit_x_o,
   output logic [10:0]        hit_y_o,
`ifdef COLLISION_LIVE_EN
   output logic               live_hit_o,
`endif
   output logic [COUNT_W-1:0] hit_count_o
);

   localparam int unsigned GraceW = (GRACE_FRAMES > 0) ? $clog2(GRACE_FRAMES + 1) : 1;
   localparam logic [COUNT_W-1:0] CountMax = {COUNT_W{1'b1}};

   typedef enum logic [1:0] {StSync, StScan, StReport} state_e;

   state_e              state_q, state_d;
   logic                sof_prev_q;
   logic                fa_q, fa_d, fp_q, fp_d, fs_q, fs_d, fb_q, fb_d;
   logic [10:0]         pend_x_q, pend_x_d, pend_y_q, pend_y_d;
   logic                alien_q, alien_d, player_q, player_d;
   logic                shield_q, shield_d, mout_q, mout_d;
   logic [10:0]         hit_x_q, hit_x_d, hit_y_q, hit_y_d;
   logic [COUNT_W-1:0]  count_q, count_d;
   logic [GraceW-1:0]   grace_q, grace_d;
   logic                live_q, live_d;

   logic sof_rise, close_frame, eval_en;
   logic ovl_a, ovl_p, ovl_s, ovl_b;

   // Only the rising sample of startOfFrame counts; a held second cycle is ordinary.
   assign sof_rise    = start_of_frame_i & ~sof_prev_q;
   assign close_frame = (state_q == StScan) & sof_rise;
   assign eval_en     = ((state_q == StScan) & ~sof_rise) | (state_q == StReport);

   assign ovl_a = missile_dr_i & alien_dr_i;
   assign ovl_p = bomb_dr_i & player_dr_i;
   // Alien overlap takes priority over shield overlap at the same pixel.
   assign ovl_s = (missile_dr_i & shield_dr_i & ~alien_dr_i) |
                  (bomb_dr_i & shield_dr_i & ~player_dr_i);
   assign ovl_b = missile_dr_i & border_dr_i;

   always_comb begin
      state_d  = state_q;
      fa_d     = fa_q;
      fp_d     = fp_q;
      fs_d     = fs_q;
      fb_d     = fb_q;
      pend_x_d = pend_x_q;
      pend_y_d = pend_y_q;
      alien_d  = 1'b0;
      player_d = 1'b0;
      shield_d = 1'b0;
      mout_d   = 1'b0;
      hit_x_d  = hit_x_q;
      hit_y_d  = hit_y_q;
      count_d  = count_q;
      grace_d  = grace_q;
      live_d   = 1'b0;

      unique case (state_q)
         StSync:   if (sof_rise) state_d = StScan;
         StScan:   if (sof_rise) state_d = StReport;
         StReport: state_d = StScan;
         default:  state_d = StSync;
      endcase

      if (close_frame) begin
         // Hand the closed frame to the pulse stage and start the next one clean.
         alien_d  = fa_q;
         player_d = fp_q & (grace_q == '0);
         shield_d = fs_q;
         mout_d   = fb_q & ~fa_q;
         if (fa_q) begin
            hit_x_d = pend_x_q;
            hit_y_d = pend_y_q;
         end
         fa_d = 1'b0;
         fp_d = 1'b0;
         fs_d = 1'b0;
         fb_d = 1'b0;
      end else if (eval_en) begin
         if (ovl_a && !fa_q) begin
            pend_x_d = pixel_x_i;
            pend_y_d = pixel_y_i;
         end
         fa_d   = fa_q | ovl_a;
         fp_d   = fp_q | ovl_p;
         fs_d   = fs_q | ovl_s;
         fb_d   = fb_q | ovl_b;
         live_d = ovl_a | ovl_p | ovl_s | ovl_b;
      end

      if ((state_q == StReport) && (grace_q != '0)) grace_d = grace_q - 1'b1;

      if (score_clear_i) begin
         count_d = '0;
      end else if (alien_q && (count_q != CountMax)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= StSync;
         sof_prev_q <= 1'b0;
         fa_q       <= 1'b0;
         fp_q       <= 1'b0;
         fs_q       <= 1'b0;
         fb_q       <= 1'b0;
         pend_x_q   <= '0;
         pend_y_q   <= '0;
         alien_q    <= 1'b0;
         player_q   <= 1'b0;
         shield_q   <= 1'b0;
         mout_q     <= 1'b0;
         hit_x_q    <= '0;
         hit_y_q    <= '0;
         count_q    <= '0;
         grace_q    <= GraceW'(GRACE_FRAMES);
         live_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sof_prev_q <= start_of_frame_i;
         fa_q       <= fa_d;
         fp_q       <= fp_d;
         fs_q       <= fs_d;
         fb_q       <= fb_d;
         pend_x_q   <= pend_x_d;
         pend_y_q   <= pend_y_d;
         alien_q    <= alien_d;
         player_q   <= player_d;
         shield_q   <= shield_d;
         mout_q     <= mout_d;
         hit_x_q    <= hit_x_d;
         hit_y_q    <= hit_y_d;
         count_q    <= count_d;
         grace_q    <= grace_d;
         live_q     <= live_d;
      end
   end

   assign alien_hit_o   = alien_q;
   assign player_hit_o  = player_q;
   assign shield_hit_o  = shield_q;
   assign missile_out_o = mout_q;
   assign hit_x_o       = hit_x_q;
   assign hit_y_o       = hit_y_q;
   assign hit_count_o   = count_q;
`ifdef COLLISION_LIVE_EN
   assign live_hit_o    = live_q;
`else
   logic unused_live;
   assign unused_live = live_q;
`endif

endmodule

// File: tb/tb_collision_arbiter.sv
// Bench for collision_arbiter (COUNT_W=2, GRACE_FRAMES=2): a directed vector
// table followed by randomized frames checked against a frame-level model.
module tb_collision_arbiter;

   localparam int unsigned CW    = 2;
   localparam int unsigned GRACE = 2;
   localparam int          CMAX  = (1 << CW) - 1;

   logic        clk = 1'b0;
   logic        reset, sof, clr;
   logic [10:0] px, py;
   logic        a_dr, p_dr, m_dr, b_dr, s_dr, bo_dr;
   logic        alien_hit, player_hit, shield_hit, missile_out;
   logic [10:0] hit_x, hit_y;
   logic [CW-1:0] hit_count;
`ifdef COLLISION_LIVE_EN
   logic        live_hit;
`endif

   collision_arbiter #(.COUNT_W(CW), .GRACE_FRAMES(GRACE)) dut (
      .clk_i           (clk),
      .reset_i         (reset),
      .start_of_frame_i(sof),
      .pixel_x_i       (px),
      .pixel_y_i       (py),
      .alien_dr_i      (a_dr),
      .player_dr_i     (p_dr),
      .missile_dr_i    (m_dr),
      .bomb_dr_i       (b_dr),
      .shield_dr_i     (s_dr),
      .border_dr_i     (bo_dr),
      .score_clear_i   (clr),
      .alien_hit_o     (alien_hit),
      .player_hit_o    (player_hit),
      .shield_hit_o    (shield_hit),
      .missile_out_o   (missile_out),
      .hit_x_o         (hit_x),
      .hit_y_o         (hit_y),
`ifdef COLLISION_LIVE_EN
      .live_hit_o      (live_hit),
`endif
      .hit_count_o     (hit_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Frame-level reference: a frame is a list of overlap events, reduced at startOfFrame.
   typedef struct {int x; int y;} pt_t;
   pt_t alien_pts[$];
   int  n_p, n_s, n_b;
   bit  m_sync, m_rep, m_prev;
   int  m_grace, m_cnt;
   int  e_pulse, e_x, e_y, e_live;

   function automatic void model_step(input bit r, input bit s, input bit c,
                                      input bit [5:0] dr, input int x, input int y);
      bit a, p, m, b, sh, bo, rise;
      {a, p, m, b, sh, bo} = dr;
      if (r) begin
         alien_pts.delete();
         n_p = 0; n_s = 0; n_b = 0;
         m_sync = 1; m_rep = 0; m_prev = 0;
         m_grace = GRACE; m_cnt = 0;
         e_pulse = 0; e_x = 0; e_y = 0; e_live = 0;
         return;
      end
      // Effects belonging to the REPORT cycle now being applied.
      if (c) m_cnt = 0;
      else if (m_rep && e_pulse[3] && m_cnt < CMAX) m_cnt++;
      if (m_rep && m_grace > 0) m_grace--;
      rise   = s && !m_prev;
      m_prev = s;
      m_rep  = 0;
      e_pulse = 0;
      e_live  = 0;
      if (m_sync) begin
         if (rise) m_sync = 0;
      end else if (rise) begin
         e_pulse[3] = alien_pts.size() > 0;
         e_pulse[2] = (n_p > 0) && (m_grace == 0);
         e_pulse[1] = n_s > 0;
         e_pulse[0] = (n_b > 0) && (alien_pts.size() == 0);
         if (alien_pts.size() > 0) begin
            e_x = alien_pts[0].x;
            e_y = alien_pts[0].y;
         end
         alien_pts.delete();
         n_p = 0; n_s = 0; n_b = 0;
         m_rep = 1;
      end else begin
         if (m && a) alien_pts.push_back('{x, y});
         if (b && p) n_p++;
         if ((m && sh && !a) || (b && sh && !p)) n_s++;
         if (m && bo) n_b++;
         e_live = ((m && a) || (b && p) || (m && sh && !a) || (b && sh && !p) || (m && bo))
                  ? 1 : 0;
      end
   endfunction

   task automatic tick(input bit r, input bit s, input bit c, input bit [5:0] dr,
                       input int x, input int y);
      reset = r; sof = s; clr = c;
      {a_dr, p_dr, m_dr, b_dr, s_dr, bo_dr} = dr;
      px = x[10:0]; py = y[10:0];
      model_step(r, s, c, dr, x, y);
      @(posedge clk);
      #1;
      check("model_pulses", int'({alien_hit, player_hit, shield_hit, missile_out}), e_pulse);
      check("model_hit_x", int'(hit_x), e_x);
      check("model_hit_y", int'(hit_y), e_y);
      check("model_count", int'(hit_count), m_cnt);
`ifdef COLLISION_LIVE_EN
      check("model_live", int'(live_hit), e_live);
`endif
   endtask

   typedef struct {
      bit       rst, sof, clr;
      bit [5:0] dr;     // {alien, player, missile, bomb, shield, border}
      int       x, y;
      bit [3:0] ep;     // {alienHit, playerHit, shieldHit, missileOut}
      int       ex, ey, ec;
   } vec_t;

   localparam bit [5:0] AM = 6'b101000;
   localparam bit [5:0] BP = 6'b010100;

   vec_t tbl[27];

   initial begin
      tbl[0]  = '{1, 0, 0, 6'b0,       0,   0, 4'b0000,   0,  0, 0};
      tbl[1]  = '{0, 0, 0, AM,         5,   5, 4'b0000,   0,  0, 0}; // SYNC: ignored
      tbl[2]  = '{0, 1, 0, 6'b0,       0,   0, 4'b0000,   0,  0, 0}; // first SOF: no pulse
      tbl[3]  = '{0, 1, 0, AM,       100,  50, 4'b0000,   0,  0, 0}; // held SOF is ordinary
      tbl[4]  = '{0, 0, 0, AM,       101,  50, 4'b0000,   0,  0, 0};
      tbl[5]  = '{0, 0, 0, BP,         7,   7, 4'b0000,   0,  0, 0};
      tbl[6]  = '{0, 1, 0, 6'b0,       0,   0, 4'b1000, 100, 50, 0}; // grace hides player
      tbl[7]  = '{0, 0, 0, 6'b0,       0,   0, 4'b0000, 100, 50, 1};
      tbl[8]  = '{0, 0, 0, 6'b111111, 200, 10, 4'b0000, 100, 50, 1};
      tbl[9]  = '{0, 1, 0, 6'b0,       0,   0, 4'b1000, 200, 10, 1};
      tbl[10] = '{0, 0, 0, 6'b0,       0,   0, 4'b0000, 200, 10, 2};
      tbl[11] = '{0, 0, 0, 6'b011111,  4,   4, 4'b0000, 200, 10, 2};
      tbl[12] = '{0, 1, 0, 6'b0,       0,   0, 4'b0111, 200, 10, 2}; // grace expired
      tbl[13] = '{0, 0, 0, AM,         9,   9, 4'b0000, 200, 10, 2}; // REPORT overlap counts
      tbl[14] = '{0, 1, 0, 6'b0,       0,   0, 4'b1000,   9,  9, 2};
      tbl[15] = '{0, 0, 0, 6'b0,       0,   0, 4'b0000,   9,  9, 3};
      tbl[16] = '{0, 0, 0, AM,         1,   1, 4'b0000,   9,  9, 3};
      tbl[17] = '{0, 1, 0, 6'b0,       0,   0, 4'b1000,   1,  1, 3};
      tbl[18] = '{0, 0, 0, 6'b0,       0,   0, 4'b0000,   1,  1, 3}; // saturated
      tbl[19] = '{0, 0, 0, AM,         2,   2, 4'b0000,   1,  1, 3};
      tbl[20] = '{0, 1, 0, 6'b0,       0,   0, 4'b1000,   2,  2, 3};
      tbl[21] = '{0, 0, 1, 6'b0,       0,   0, 4'b0000,   2,  2, 0}; // clear beats increment
      tbl[22] = '{0, 0, 0, AM,         3,   3, 4'b0000,   2,  2, 0};
      tbl[23] = '{1, 0, 0, 6'b0,       0,   0, 4'b0000,   0,  0, 0}; // reset mid-SCAN
      tbl[24] = '{0, 1, 0, 6'b0,       0,   0, 4'b0000,   0,  0, 0};
      tbl[25] = '{0, 0, 0, 6'b0,       0,   0, 4'b0000,   0,  0, 0};
      tbl[26] = '{0, 1, 0, 6'b0,       0,   0, 4'b0000,   0,  0, 0}; // latched overlap discarded

      for (int i = 0; i < 27; i++) begin
         tick(tbl[i].rst, tbl[i].sof, tbl[i].clr, tbl[i].dr, tbl[i].x, tbl[i].y);
         check($sformatf("vec%0d_pulses", i),
               int'({alien_hit, player_hit, shield_hit, missile_out}), int'(tbl[i].ep));
         check($sformatf("vec%0d_hit_x", i), int'(hit_x), tbl[i].ex);
         check($sformatf("vec%0d_hit_y", i), int'(hit_y), tbl[i].ey);
         check($sformatf("vec%0d_count", i), int'(hit_count), tbl[i].ec);
      end

      // Randomized frames of varying length with occasional held SOF, clears and resets.
      for (int i = 0; i < 4000; i++) begin
         bit       r, s, c;
         bit [5:0] dr;
         r = ($urandom_range(0, 499) == 0);
         s = ($urandom_range(0, 19) == 0);
         c = ($urandom_range(0, 79) == 0);
         for (int k = 0; k < 6; k++) dr[k] = ($urandom_range(0, 3) == 0);
         tick(r, s, c, dr, int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/collision_arbiter.md
Name: collision_arbiter

Overview:
- Consumes the per-pixel drawing-request outputs of all on-screen objects: alien formation, player, player missile, alien bomb, shields, border.
- Detects overlaps while the raster scans a frame and latches them.
- At each startOfFrame, issues frame-aligned one-cycle collision pulses back to the object blocks. alienHit drives the alien block's collision input.
- Also reports the first alien-hit coordinate and a saturating score counter.

Parameters:
- COUNT_W, 8, width of hitCount.
- GRACE_FRAMES, 60, number of complete frames after reset during which playerHit is suppressed.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- startOfFrame  input  1  one-cycle pulse per frame, from the VGA controller
- pixelX  input  11  current raster X
- pixelY  input  11  current raster Y
- alienDR  input  1  alien formation drawing request
- playerDR  input  1  player drawing request
- missileDR  input  1  player missile drawing request
- bombDR  input  1  alien bomb drawing request
- shieldDR  input  1  shield drawing request
- borderDR  input  1  screen border drawing request
- scoreClear  input  1  synchronous clear of hitCount
- alienHit  output  1  pulse: missile hit alien in the closed frame
- playerHit  output  1  pulse: bomb hit player
- shieldHit  output  1  pulse: missile or bomb hit shield
- missileOut  output  1  pulse: missile hit border with no alien hit
- hitX  output  11  X of the first alien-hit pixel
- hitY  output  11  Y of the first alien-hit pixel
- hitCount  output  COUNT_W  saturating alien-hit count

Behaviour:
- Clock and reset: single clock domain. reset is synchronous, active-high, and takes priority over every other input.
- Reset values: all pulse outputs 0; hitX, hitY, hitCount 0; all internal flags 0; grace counter = GRACE_FRAMES; state SYNC.
- State SYNC (after reset or reset mid-frame):
  - DR inputs are ignored; the partial frame is discarded.
  - First sampled startOfFrame goes to SCAN. No pulses are issued.
- State SCAN: each cycle, with startOfFrame=0, the DR inputs are evaluated at the current pixel:
  - missileDR&alienDR sets fA. On the first such pixel of the frame (fA was 0), pixelX/pixelY are captured into pending registers.
  - bombDR&playerDR sets fP.
  - (missileDR&shieldDR&!alienDR) | (bombDR&shieldDR&!playerDR) sets fS. An alien overlap has priority over a shield overlap at the same pixel.
  - missileDR&borderDR sets fB.
  - Overlaps in the startOfFrame cycle itself are ignored.
- startOfFrame sampled in SCAN at cycle N → state REPORT for cycle N+1. Flags and pending coordinates are copied to the report stage and cleared in cycle N.
- State REPORT (exactly one cycle): outputs are valid in this cycle only.
  - alienHit = fA.
  - playerHit = fP & (grace counter == 0).
  - shieldHit = fS.
  - missileOut = fB & !fA.
  - If fA: hitX/hitY are updated from the pending registers, visible from cycle N+1. Otherwise they hold their previous values.
  - Overlaps sampled during REPORT count toward the new frame.
  - Next state: SCAN.
- At most one pulse of each type per frame, regardless of how many overlap pixels occur.
- Grace counter decrements by 1 at each REPORT while nonzero.
- hitCount:
  - Increments by 1 in the REPORT cycle when alienHit=1.
  - Saturates at 2^COUNT_W−1.
  - scoreClear zeroes it. If scoreClear and an increment coincide, the clear wins.
- startOfFrame held high for two consecutive cycles: the second cycle is treated as an ordinary cycle. Only the rising sample counts.
- Sampling convention: DR inputs are assumed registered by their producers. The arbiter compares them against the same-cycle pixelX/pixelY, and the producers are responsible for alignment.

Optional Feature:
- Macro: COLLISION_LIVE_EN.
- Defined: adds output liveHit (1 bit). liveHit = registered OR of all raw overlap terms, asserted the cycle after any overlap pixel in SCAN or REPORT. It is used for immediate sound/flash feedback and is 0 in SYNC and during reset.
- Undefined: the port and logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then startOfFrame at cycle 10. Overlap missileDR&alienDR at (100,50) and (101,50), then SOF at cycle 500 → alienHit=1 at cycle 501 only; hitX=100, hitY=50; hitCount=1.
- Overlap asserted before the first SOF after reset → no pulse at the first SOF. Overlap at the second SOF → pulse.
- GRACE_FRAMES=2; bomb/player overlap in frames 1, 2 and 3 → playerHit 0, 0, 1 at the successive REPORTs.
- Same pixel: missileDR, alienDR, shieldDR and borderDR all 1 → alienHit=1, shieldHit=0, missileOut=0.
- COUNT_W=2; four consecutive frames with alien hits → hitCount 1, 2, 3, 3. scoreClear asserted in the same cycle as a 5th alien hit → hitCount=0.
- reset asserted mid-SCAN after an overlap has been latched → no pulse at the next SOF (state SYNC), all outputs 0. With COLLISION_LIVE_EN defined, liveHit is high one cycle after each overlap pixel.
